// File: rtl/movegen_sequencer.sv
// movegen_sequencer: drives the attack-array core over its command bus to enumerate
// captures in MVV-LVA order and streams them out over a valid/ready handshake.
module movegen_sequencer #(
   parameter int RESULT_LAT = 1,
   parameter int MAX_MOVES  = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       wtm,
   input  logic       abort,
   output logic [7:0] core_cmd,
   output logic [7:0] core_data,
   input  logic [7:0] core_result,
   output logic       move_valid,
   input  logic       move_ready,
   output logic [5:0] move_from,
   output logic [5:0] move_to,
   output logic [7:0] move_count,
   output logic       busy,
   output logic       done,
   output logic       illegal_pos
);
   typedef enum logic [3:0] {
      IDLE, V_CLR, V_REPLAY, V_FIND, V_WAIT, A_CLR, A_FIND, A_WAIT, EMIT, A_DIS, FINISH
   } state_t;
   localparam logic [1:0] LAT  = RESULT_LAT[1:0];
   localparam logic [7:0] MAXC = MAX_MOVES[7:0];
   state_t      state_q;
   logic [63:0] vdone_q;
   logic [5:0]  scan_q, victim_q, aggr_q;
   logic [1:0]  wcnt_q;
   logic [7:0]  cmd_q, data_q, count_q;
   logic        wtm_q, valid_q, busy_q, done_q, illegal_q;
   logic [7:0]  count_d;
   assign count_d     = count_q + {7'd0, count_q != 8'hFF};
   assign core_cmd    = cmd_q;
   assign core_data   = data_q;
   assign move_valid  = valid_q;
   assign move_from   = aggr_q;
   assign move_to     = victim_q;
   assign move_count  = count_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign illegal_pos = illegal_q;
   // Commands are registered, so each one appears on the bus in the cycle after
   // the state that issues it; wait states count from that presentation cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         vdone_q   <= '0;
         scan_q    <= '0;
         victim_q  <= '0;
         aggr_q    <= '0;
         wcnt_q    <= '0;
         cmd_q     <= 8'h00;
         data_q    <= 8'h00;
         count_q   <= 8'h00;
         wtm_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         cmd_q  <= 8'h00;
         data_q <= 8'h00;
         done_q <= 1'b0;
         if (abort && state_q != IDLE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (start) begin
                  wtm_q     <= wtm;
                  vdone_q   <= '0;
                  count_q   <= 8'h00;
                  illegal_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= V_CLR;
               end
               V_CLR: begin
                  cmd_q   <= 8'hC0;
                  scan_q  <= '0;
                  state_q <= V_REPLAY;
               end
               V_REPLAY: begin
                  if (vdone_q[scan_q]) begin
                     cmd_q  <= {6'b110100, scan_q[5:4]};
                     data_q <= {scan_q[3:0], 4'b0000};
                  end
                  scan_q <= scan_q + 6'd1;
                  if (scan_q == 6'd63) state_q <= V_FIND;
               end
               V_FIND: begin
                  cmd_q   <= 8'hE0;
                  data_q  <= {7'd0, wtm_q};
                  wcnt_q  <= '0;
                  state_q <= V_WAIT;
               end
               V_WAIT: begin
                  if (wcnt_q != LAT) wcnt_q <= wcnt_q + 2'd1;
                  else if (core_result[7] || core_result[6]) begin
                     illegal_q <= core_result[7];
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= FINISH;
                  end else begin
                     victim_q <= core_result[5:0];
                     state_q  <= A_CLR;
                  end
               end
               A_CLR: begin
                  cmd_q   <= 8'hC0;
                  state_q <= A_FIND;
               end
               A_FIND: begin
                  cmd_q   <= {6'b111100, victim_q[5:4]};
                  data_q  <= {victim_q[3:0], 3'b000, wtm_q};
                  wcnt_q  <= '0;
                  state_q <= A_WAIT;
               end
               A_WAIT: begin
                  if (wcnt_q != LAT) wcnt_q <= wcnt_q + 2'd1;
                  else if (core_result[6]) begin
                     vdone_q[victim_q] <= 1'b1;
                     state_q           <= V_CLR;
                  end else begin
                     aggr_q  <= core_result[5:0];
                     valid_q <= 1'b1;
                     state_q <= EMIT;
                  end
               end
               EMIT: if (move_ready) begin
                  valid_q <= 1'b0;
                  count_q <= count_d;
                  if (count_d == MAXC) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= FINISH;
                  end else state_q <= A_DIS;
               end
               A_DIS: begin
                  cmd_q   <= {6'b110100, aggr_q[5:4]};
                  data_q  <= {aggr_q[3:0], 4'b0000};
                  state_q <= A_FIND;
               end
               FINISH:  state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_movegen_sequencer.sv
// tb_movegen_sequencer: three sequencer instances (LAT1/MAX255, LAT3/MAX255, LAT1/MAX2),
// each driving a board-described attack-array core model with its own enable mask.
module tb_movegen_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   int total = 0;
   int bad = 0;
   logic       st[3], wt[3], ab[3], mr[3], mv[3], bz[3], dn[3], il[3];
   logic [7:0] cmd[3], dat[3], mc[3];
   logic [5:0] mf[3], mt[3];
   // board: victims listed most valuable first, each with attackers least valuable first
   int          nv[3], na[3][8];
   logic [5:0]  vsq[3][8], asq[3][8][8];
   logic        ill[3], wexp[3];
   logic [11:0] exp_mv[3][64];
   int          exp_n[3], base[3], acc[3], dis_n[3];
   logic [15:0] dis_last[3];
   logic [11:0] last_mv[3];

   task automatic check(input logic ok, input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : u
      logic [7:0]  cr = 8'hFF;
      logic [63:0] en = '1;
      logic [7:0]  pres = 8'h40;
      int          pend = 0;
      int          k;
      movegen_sequencer #(.RESULT_LAT(g == 1 ? 3 : 1), .MAX_MOVES(g == 2 ? 2 : 255)) dut (
         .clk(clk), .rst_n(rst_n), .start(st[g]), .wtm(wt[g]), .abort(ab[g]),
         .core_cmd(cmd[g]), .core_data(dat[g]), .core_result(cr),
         .move_valid(mv[g]), .move_ready(mr[g]), .move_from(mf[g]), .move_to(mt[g]),
         .move_count(mc[g]), .busy(bz[g]), .done(dn[g]), .illegal_pos(il[g]));
      // result is only meaningful in the sample cycle; garbage elsewhere
      initial forever begin : core
         @(negedge clk);
         cr = 8'hFF;
         if (pend > 0) begin
            pend--;
            if (pend == 0) cr = pres;
            check(cmd[g] == 8'h00 && dat[g] == 8'h00, "find_nop", {cmd[g], dat[g]}, 0);
         end
         if (cmd[g] == 8'hC0) en = '1;
         else if (cmd[g][7:2] == 6'b110100) begin
            en[{cmd[g][1:0], dat[g][7:4]}] = dat[g][0];
            if (!dat[g][0]) begin
               dis_n[g]++;
               dis_last[g] = {cmd[g], dat[g]};
            end
         end else if (cmd[g] == 8'hE0) begin
            check(dat[g] == {7'd0, wexp[g]}, "findv_data", dat[g], {7'd0, wexp[g]});
            pres = ill[g] ? 8'h84 : 8'h40;
            for (int v = nv[g] - 1; v >= 0; v--)
               if (!ill[g] && en[vsq[g][v]]) pres = {2'b00, vsq[g][v]};
            pend = g == 1 ? 3 : 1;
         end else if (cmd[g][7:2] == 6'b111100) begin
            check(dat[g][3:0] == {3'd0, wexp[g]}, "finda_data", dat[g], {3'd0, wexp[g]});
            pres = 8'h40;
            for (int v = 0; v < nv[g]; v++)
               if (vsq[g][v] == {cmd[g][1:0], dat[g][7:4]})
                  for (int j = na[g][v] - 1; j >= 0; j--)
                     if (en[asq[g][v][j]]) pres = {2'b00, asq[g][v][j]};
            pend = g == 1 ? 3 : 1;
         end
      end
      initial forever begin : cmp
         @(negedge clk);
         if (mv[g] === 1'b1) begin
            k = acc[g] - base[g];
            check(k < exp_n[g] && {mf[g], mt[g]} == exp_mv[g][k], "move", {mf[g], mt[g]},
                  k < exp_n[g] ? {20'd0, exp_mv[g][k]} : 32'hFFFF);
         end
      end
      initial forever begin : hs
         @(posedge clk);
         if (rst_n && mv[g] && mr[g] && !ab[g]) begin
            last_mv[g] = {mf[g], mt[g]};
            acc[g]++;
         end
      end
   end

   task automatic go(input int i, input logic w);
      wexp[i] = w;
      base[i] = acc[i];
      exp_n[i] = 0;
      if (!ill[i])
         for (int v = 0; v < nv[i]; v++)
            for (int j = 0; j < na[i][v]; j++)
               if (exp_n[i] < (i == 2 ? 2 : 255)) begin
                  exp_mv[i][exp_n[i]] = {asq[i][v][j], vsq[i][v]};
                  exp_n[i]++;
               end
      wt[i] = w;
      st[i] = 1'b1;
      @(negedge clk);
      st[i] = 1'b0;
   endtask

   task automatic fin(input int i);
      int t = 0;
      while (dn[i] !== 1'b1 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check(dn[i] === 1'b1, "done_seen", t, 5000);
      check(mc[i] == 8'(exp_n[i]), "count", mc[i], exp_n[i]);
      check(acc[i] - base[i] == exp_n[i], "consumed", acc[i] - base[i], exp_n[i]);
      check(il[i] == ill[i], "illegal", il[i], ill[i]);
      check(bz[i] == 1'b0 && mv[i] == 1'b0, "idle_flags", {bz[i], mv[i]}, 0);
      @(negedge clk);
      check(dn[i] == 1'b0, "done_pulse", dn[i], 0);
   endtask

   task automatic wait_mv(input int i);
      int t = 0;
      while (mv[i] !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check(mv[i] === 1'b1, "valid_seen", t, 1000);
   endtask

   task automatic rich(input int i);
      nv[i] = 3;
      vsq[i][0] = 6'd20; na[i][0] = 3;
      asq[i][0][0] = 6'd3; asq[i][0][1] = 6'd40; asq[i][0][2] = 6'd12;
      vsq[i][1] = 6'd33; na[i][1] = 0;
      vsq[i][2] = 6'd7;  na[i][2] = 1; asq[i][2][0] = 6'd62;
   endtask

   task automatic one(input int i, input logic [5:0] v, input logic [5:0] a);
      nv[i] = 1; vsq[i][0] = v; na[i][0] = 1; asq[i][0][0] = a;
   endtask

   initial begin
      int d0, c, t;
      logic nd;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0; wt[i] = 1'b0; ab[i] = 1'b0; mr[i] = 1'b1; ill[i] = 1'b0; nv[i] = 0;
      end
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++)
         check({mv[i], bz[i], dn[i], il[i], mc[i], mf[i], mt[i], cmd[i], dat[i]} == '0, "reset_state",
               {mv[i], bz[i], dn[i], il[i], mc[i], cmd[i], dat[i]}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // single victim 56 attacked from square 0
      one(0, 6'd56, 6'd0);
      d0 = dis_n[0];
      go(0, 1'b0); fin(0);
      check(mc[0] == 8'd1, "t1_count", mc[0], 1);
      check(last_mv[0] == {6'd0, 6'd56}, "t1_move", last_mv[0], {6'd0, 6'd56});
      check(dis_n[0] - d0 == 2, "t1_disables", dis_n[0] - d0, 2);
      check(dis_last[0] == 16'hD380, "t1_replay_cmd", dis_last[0], 16'hD380);
      // three victims, one of them unattacked, black to move
      rich(0);
      go(0, 1'b1); fin(0);
      check(mc[0] == 8'd4, "t2_count", mc[0], 4);
      check(last_mv[0] == {6'd62, 6'd7}, "t2_last", last_mv[0], {6'd62, 6'd7});
      // enemy king capturable
      ill[0] = 1'b1;
      go(0, 1'b0); fin(0);
      repeat (3) @(negedge clk);
      check(il[0] == 1'b1, "illegal_hold", il[0], 1);
      ill[0] = 1'b0; nv[0] = 0;
      go(0, 1'b1);
      check(il[0] == 1'b0, "illegal_clear", il[0], 0);
      fin(0);
      // downstream stall of 10 cycles
      one(0, 6'd9, 6'd17);
      mr[0] = 1'b0;
      go(0, 1'b0); wait_mv(0);
      for (int n = 0; n < 10; n++) begin
         check(mv[0] == 1'b1 && {mf[0], mt[0]} == {6'd17, 6'd9} && mc[0] == 8'd0, "stall_hold",
               {mv[0], mf[0], mt[0], mc[0]}, {1'b1, 6'd17, 6'd9, 8'd0});
         if (n < 9) @(negedge clk);
      end
      mr[0] = 1'b1;
      fin(0);
      check(mc[0] == 8'd1, "stall_count", mc[0], 1);
      // three-cycle result latency
      rich(1);
      go(1, 1'b1); fin(1);
      check(mc[1] == 8'd4, "lat3_count", mc[1], 4);
      // move limit of 2
      nv[2] = 1; vsq[2][0] = 6'd10; na[2][0] = 3;
      asq[2][0][0] = 6'd5; asq[2][0][1] = 6'd7; asq[2][0][2] = 6'd9;
      go(2, 1'b0); fin(2);
      check(mc[2] == 8'd2, "max_count", mc[2], 2);
      check(last_mv[2] == {6'd7, 6'd10}, "max_last", last_mv[2], {6'd7, 6'd10});
      // abort at scan 30 of the second victim replay
      one(0, 6'd56, 6'd0);
      go(0, 1'b0);
      c = 0; t = 0;
      while (c < 3 && t < 2000) begin
         @(negedge clk);
         t++;
         if (cmd[0] == 8'hC0) c++;
      end
      check(c == 3, "abort_reach", c, 3);
      repeat (30) @(negedge clk);
      ab[0] = 1'b1;
      @(negedge clk);
      ab[0] = 1'b0;
      check({bz[0], cmd[0], dn[0], mv[0]} == '0, "abort_idle", {bz[0], cmd[0], dn[0], mv[0]}, 0);
      check(mc[0] == 8'd1, "abort_count_hold", mc[0], 1);
      nd = 1'b0;
      repeat (5) begin
         @(negedge clk);
         nd = nd | dn[0];
      end
      check(nd == 1'b0, "abort_no_done", nd, 0);
      go(0, 1'b0); fin(0);
      // abort coincident with ready
      one(0, 6'd9, 6'd17);
      mr[0] = 1'b0;
      go(0, 1'b0); wait_mv(0);
      mr[0] = 1'b1; ab[0] = 1'b1;
      @(negedge clk);
      ab[0] = 1'b0;
      check({mc[0], mv[0], bz[0]} == '0, "abort_ready", {mc[0], mv[0], bz[0]}, 0);
      // asynchronous reset while a move is pending
      mr[0] = 1'b0;
      go(0, 1'b1); wait_mv(0);
      #1 rst_n = 1'b0;
      #1 check({mv[0], bz[0], dn[0], il[0], mc[0], mf[0], mt[0], cmd[0], dat[0]} == '0, "async_reset",
               {mv[0], bz[0], mf[0], mt[0]}, 0);
      @(negedge clk);
      rst_n = 1'b1; mr[0] = 1'b1;
      @(negedge clk);
      one(0, 6'd56, 6'd0);
      go(0, 1'b0); fin(0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
